// File: rtl/elevator_pkg.sv
// Shared elevator definitions: building size, call direction and hall-call FSM states.
// The building dispatcher imports this package as well.
package elevator_pkg;

   localparam int unsigned NUM_FLOORS = 8;
   localparam int unsigned FLOOR_W    = $clog2(NUM_FLOORS);

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   typedef enum logic [0:0] {
      StScan,
      StPresent
   } hall_state_e;

endpackage

// File: rtl/rr_slot_finder.sv
// Rotating find-first over the pending-slot vector, searching upward from ptr and wrapping.
module rr_slot_finder
   import elevator_pkg::*;
#(
   parameter int unsigned SLOTS  = 2 * NUM_FLOORS,
   localparam int unsigned SLOT_W = $clog2(SLOTS)
) (
   input  logic [SLOTS-1:0]  pending,
   input  logic [SLOT_W-1:0] ptr,
   output logic              hit,
   output logic [SLOT_W-1:0] slot
);

   always_comb begin
      hit  = 1'b0;
      slot = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (!hit && pending[(int'(ptr) + i) % SLOTS]) begin
            hit  = 1'b1;
            slot = SLOT_W'((int'(ptr) + i) % SLOTS);
         end
      end
   end

endmodule

// File: rtl/hall_call_manager.sv
// Latches hall up/down calls and presents them one at a time to the dispatcher,
// rotating fairly and skipping a call that is not accepted within PRESENT_TIMEOUT cycles.
module hall_call_manager #(
   parameter int unsigned NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
   parameter int unsigned PRESENT_TIMEOUT = 15,
   localparam int unsigned FLOOR_W        = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] hall_up_btn,
   input  logic [NUM_FLOORS-1:0] hall_down_btn,
   input  logic                  dispatch_elev_1,
   input  logic                  dispatch_elev_2,
   output logic                  request_valid,
   output logic [FLOOR_W-1:0]    request_floor,
   output logic                  request_dir,
   output logic [NUM_FLOORS-1:0] up_pending,
   output logic [NUM_FLOORS-1:0] down_pending
);

   import elevator_pkg::*;

   localparam int unsigned SLOTS  = 2 * NUM_FLOORS;
   localparam int unsigned SLOT_W = $clog2(SLOTS);
   localparam int unsigned CNT_W  = $clog2(PRESENT_TIMEOUT + 1);

   hall_state_e       state_q;
   logic [SLOTS-1:0]  pend_q, pend_d, set_vec, clr_vec;
   logic [SLOT_W-1:0] ptr_q, slot_q, hit_slot, ptr_next;
   logic [CNT_W-1:0]  cnt_q;
   logic              valid_q, hit, dispatch, timeout;

   assign dispatch = dispatch_elev_1 | dispatch_elev_2;
   assign timeout  = (cnt_q == CNT_W'(PRESENT_TIMEOUT - 1));
   assign ptr_next = (slot_q == SLOT_W'(SLOTS - 1)) ? '0 : slot_q + 1'b1;

   // Slot = floor*2 + dir; top-floor up and ground-floor down buttons do not exist.
   always_comb begin
      set_vec = '0;
      for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
         set_vec[2*f + int'(DIR_UP)]   = hall_up_btn[f] & (f != NUM_FLOORS - 1);
         set_vec[2*f + int'(DIR_DOWN)] = hall_down_btn[f] & (f != 0);
      end
   end

   // An accepted call clears its slot even if its button is sampled high on the same edge.
   always_comb begin
      clr_vec = '0;
      if (state_q == StPresent && dispatch) begin
         clr_vec[slot_q] = 1'b1;
      end
      pend_d = (pend_q | set_vec) & ~clr_vec;
   end

   always_comb begin
      up_pending   = '0;
      down_pending = '0;
      for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
         up_pending[f]   = pend_q[2*f + int'(DIR_UP)];
         down_pending[f] = pend_q[2*f + int'(DIR_DOWN)];
      end
   end

   rr_slot_finder #(
      .SLOTS (SLOTS)
   ) u_finder (
      .pending (pend_q),
      .ptr     (ptr_q),
      .hit     (hit),
      .slot    (hit_slot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StScan;
         pend_q  <= '0;
         ptr_q   <= '0;
         slot_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         unique case (state_q)
            StScan: begin
               if (hit) begin
                  slot_q  <= hit_slot;
                  cnt_q   <= '0;
                  valid_q <= 1'b1;
                  state_q <= StPresent;
               end
            end
            StPresent: begin
               // Dispatch and timeout both leave; only dispatch clears the slot.
               if (dispatch || timeout) begin
                  valid_q <= 1'b0;
                  ptr_q   <= ptr_next;
                  state_q <= StScan;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= StScan;
            end
         endcase
      end
   end

   assign request_valid = valid_q;
   assign request_floor = slot_q[SLOT_W-1:1];
   assign request_dir   = slot_q[0];

endmodule

// File: tb/tb_hall_call_manager.sv
// Directed bench for hall_call_manager: hand-computed expectations checked with immediate assertions.
module tb_hall_call_manager;

   logic       clk;
   logic       rst_n;
   logic [7:0] hall_up_btn;
   logic [7:0] hall_down_btn;
   logic       dispatch_elev_1;
   logic       dispatch_elev_2;
   logic       request_valid;
   logic [2:0] request_floor;
   logic       request_dir;
   logic [7:0] up_pending;
   logic [7:0] down_pending;

   int checks = 0;
   int errors = 0;
   logic all_high;

   hall_call_manager #(
      .NUM_FLOORS      (8),
      .PRESENT_TIMEOUT (15)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .hall_up_btn     (hall_up_btn),
      .hall_down_btn   (hall_down_btn),
      .dispatch_elev_1 (dispatch_elev_1),
      .dispatch_elev_2 (dispatch_elev_2),
      .request_valid   (request_valid),
      .request_floor   (request_floor),
      .request_dir     (request_dir),
      .up_pending      (up_pending),
      .down_pending    (down_pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_req(input string tag, input logic v, input logic [2:0] fl, input logic d);
      chk({tag, "_valid"}, 32'(request_valid), 32'(v));
      if (v) begin
         chk({tag, "_floor"}, 32'(request_floor), 32'(fl));
         chk({tag, "_dir"}, 32'(request_dir), 32'(d));
      end
   endtask

   initial begin
      rst_n           = 1'b0;
      hall_up_btn     = '0;
      hall_down_btn   = '0;
      dispatch_elev_1 = 1'b0;
      dispatch_elev_2 = 1'b0;

      // Reset state
      #3;
      chk("rst_valid", 32'(request_valid), 32'd0);
      chk("rst_floor", 32'(request_floor), 32'd0);
      chk("rst_dir", 32'(request_dir), 32'd0);
      chk("rst_up", 32'(up_pending), 32'd0);
      chk("rst_down", 32'(down_pending), 32'd0);
      #9 rst_n = 1'b1;
      step();

      // Single up call at floor 3, minimum latency, then dispatch
      hall_up_btn[3] = 1'b1;
      step();
      hall_up_btn = '0;
      chk("t1_up_n1", 32'(up_pending), 32'h08);
      chk("t1_valid_n1", 32'(request_valid), 32'd0);
      step();
      chk_req("t1_n2", 1'b1, 3'd3, 1'b1);
      dispatch_elev_1 = 1'b1;
      step();
      dispatch_elev_1 = 1'b0;
      chk("t1_up_clr", 32'(up_pending), 32'd0);
      chk("t1_valid_clr", 32'(request_valid), 32'd0);
      step();
      chk("t1_idle", 32'(request_valid), 32'd0);

      // Rotation order from pointer 0: (2,up) (5,down) (6,up)
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      hall_up_btn[2]   = 1'b1;
      hall_up_btn[6]   = 1'b1;
      hall_down_btn[5] = 1'b1;
      step();
      hall_up_btn   = '0;
      hall_down_btn = '0;
      chk("t2_up", 32'(up_pending), 32'h44);
      chk("t2_down", 32'(down_pending), 32'h20);
      step();
      chk_req("t2_a", 1'b1, 3'd2, 1'b1);
      dispatch_elev_2 = 1'b1;
      step();
      dispatch_elev_2 = 1'b0;
      chk("t2_gap_a", 32'(request_valid), 32'd0);
      step();
      chk_req("t2_b", 1'b1, 3'd5, 1'b0);
      dispatch_elev_1 = 1'b1;
      step();
      dispatch_elev_1 = 1'b0;
      chk("t2_gap_b", 32'(request_valid), 32'd0);
      step();
      chk_req("t2_c", 1'b1, 3'd6, 1'b1);
      dispatch_elev_1 = 1'b1;
      step();
      dispatch_elev_1 = 1'b0;
      step();
      step();
      chk("t2_done_valid", 32'(request_valid), 32'd0);
      chk("t2_done_up", 32'(up_pending), 32'd0);
      chk("t2_done_down", 32'(down_pending), 32'd0);

      // Timeout: up@1 presented 15 cycles, one SCAN cycle, re-presented
      hall_up_btn[1] = 1'b1;
      step();
      hall_up_btn = '0;
      step();
      chk_req("t3_first", 1'b1, 3'd1, 1'b1);
      all_high = 1'b1;
      for (int i = 0; i < 14; i++) begin
         step();
         all_high &= request_valid;
      end
      chk("t3_15_cycles", 32'(all_high), 32'd1);
      step();
      chk("t3_scan_gap", 32'(request_valid), 32'd0);
      chk("t3_kept", 32'(up_pending), 32'h02);
      step();
      chk_req("t3_again", 1'b1, 3'd1, 1'b1);

      // Both dispatches on the 15th cycle: dispatch beats timeout
      for (int i = 0; i < 14; i++) step();
      chk("t4_cycle15", 32'(request_valid), 32'd1);
      dispatch_elev_1 = 1'b1;
      dispatch_elev_2 = 1'b1;
      step();
      dispatch_elev_1 = 1'b0;
      dispatch_elev_2 = 1'b0;
      chk("t4_cleared", 32'(up_pending), 32'd0);
      chk("t4_valid", 32'(request_valid), 32'd0);
      step();
      step();
      chk("t4_no_repres", 32'(request_valid), 32'd0);

      // Nonexistent buttons held high
      hall_up_btn[7]   = 1'b1;
      hall_down_btn[0] = 1'b1;
      step();
      step();
      step();
      chk("t5_up", 32'(up_pending), 32'd0);
      chk("t5_down", 32'(down_pending), 32'd0);
      chk("t5_valid", 32'(request_valid), 32'd0);
      hall_up_btn   = '0;
      hall_down_btn = '0;

      // Button on presented slot coincident with dispatch: clear wins
      hall_up_btn[4] = 1'b1;
      step();
      hall_up_btn = '0;
      step();
      chk_req("t6_pres", 1'b1, 3'd4, 1'b1);
      hall_up_btn[4]  = 1'b1;
      dispatch_elev_1 = 1'b1;
      step();
      hall_up_btn     = '0;
      dispatch_elev_1 = 1'b0;
      chk("t6_clear_wins", 32'(up_pending), 32'd0);
      step();
      chk("t6_valid", 32'(request_valid), 32'd0);

      // Dispatch outside PRESENT is ignored
      hall_up_btn[5]  = 1'b1;
      dispatch_elev_1 = 1'b1;
      step();
      hall_up_btn     = '0;
      dispatch_elev_1 = 1'b0;
      chk("t7_kept", 32'(up_pending), 32'h20);
      step();
      chk_req("t7_pres", 1'b1, 3'd5, 1'b1);
      dispatch_elev_2 = 1'b1;
      step();
      dispatch_elev_2 = 1'b0;

      // Pointer wrap: after slot 14 (down@7), search wraps to slot 1 (up@0)
      hall_down_btn[7] = 1'b1;
      step();
      hall_down_btn = '0;
      step();
      chk_req("t8_d7", 1'b1, 3'd7, 1'b0);
      hall_up_btn[0]   = 1'b1;
      hall_down_btn[1] = 1'b1;
      dispatch_elev_1  = 1'b1;
      step();
      hall_up_btn     = '0;
      hall_down_btn   = '0;
      dispatch_elev_1 = 1'b0;
      step();
      chk_req("t8_wrap", 1'b1, 3'd0, 1'b1);
      dispatch_elev_1 = 1'b1;
      step();
      dispatch_elev_1 = 1'b0;
      step();
      chk_req("t8_next", 1'b1, 3'd1, 1'b0);
      dispatch_elev_2 = 1'b1;
      step();
      dispatch_elev_2 = 1'b0;

      // Asynchronous reset mid-PRESENT with three pending calls
      hall_up_btn[1]   = 1'b1;
      hall_up_btn[4]   = 1'b1;
      hall_down_btn[3] = 1'b1;
      step();
      hall_up_btn   = '0;
      hall_down_btn = '0;
      step();
      chk("t9_pres", 32'(request_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t9_valid", 32'(request_valid), 32'd0);
      chk("t9_floor", 32'(request_floor), 32'd0);
      chk("t9_dir", 32'(request_dir), 32'd0);
      chk("t9_up", 32'(up_pending), 32'd0);
      chk("t9_down", 32'(down_pending), 32'd0);
      #1 rst_n = 1'b1;
      step();
      step();
      chk("t9_after_valid", 32'(request_valid), 32'd0);
      chk("t9_after_up", 32'(up_pending), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hall_call_manager.md
HALL_CALL_MANAGER -- requirements
Module: hall_call_manager

Interface
REQ-001 Parameter NUM_FLOORS, default 8, number of served floors; FLOOR_W = $clog2(NUM_FLOORS) = 3.
REQ-002 Parameter PRESENT_TIMEOUT, default 15, max cycles one call is presented before it is skipped.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 hall_up_btn  input  NUM_FLOORS  level hall "up" buttons, bit i = floor i.
REQ-006 hall_down_btn  input  NUM_FLOORS  level hall "down" buttons, bit i = floor i.
REQ-007 dispatch_elev_1  input  1  dispatcher accepted presented call for car 1.
REQ-008 dispatch_elev_2  input  1  dispatcher accepted presented call for car 2.
REQ-009 request_valid  output  1  request_floor/request_dir carry a pending call.
REQ-010 request_floor  output  FLOOR_W  floor of presented call.
REQ-011 request_dir  output  1  direction of presented call, 1 = up, 0 = down.
REQ-012 up_pending  output  NUM_FLOORS  registered up-call lamps.
REQ-013 down_pending  output  NUM_FLOORS  registered down-call lamps.

Function
REQ-014 Slot index = floor*2 + dir; 2*NUM_FLOORS slots; slot pending bit set one cycle after its button is sampled high.
REQ-015 hall_up_btn[NUM_FLOORS-1] and hall_down_btn[0] are ignored; those pending bits stay 0.
REQ-016 FSM states SCAN, PRESENT; reset state SCAN.
REQ-017 SCAN: rotating find-first over pending slots starting at scan pointer; hit -> latch slot, go PRESENT next cycle; no hit -> stay SCAN.
REQ-018 request_valid is 1 only in PRESENT; request_floor/request_dir are registered and held stable for the whole PRESENT interval.
REQ-019 Minimum latency: button high at edge n -> pending at n+1 -> request_valid at n+2 when no other call is presented.
REQ-020 PRESENT with dispatch_elev_1 or dispatch_elev_2 high at an edge (either or both) -> clear presented slot's pending bit, pointer = slot+1 mod 2*NUM_FLOORS, go SCAN; request_valid low next cycle.
REQ-021 PRESENT with no dispatch for PRESENT_TIMEOUT consecutive cycles -> pending bit kept, pointer = slot+1 mod 2*NUM_FLOORS, go SCAN (starvation avoidance).
REQ-022 Dispatch and timeout on the same edge -> dispatch wins (slot cleared).
REQ-023 Button high on the presented slot in the same edge as dispatch -> clear wins; bit set again only if the button is still high on a later edge.
REQ-024 Dispatch inputs outside PRESENT are ignored.
REQ-025 Timeout counter width = $clog2(PRESENT_TIMEOUT+1); reset to 0 on every PRESENT entry; no wrap.
REQ-026 Pointer wraps from slot 2*NUM_FLOORS-1 to 0.

Reset
REQ-027 rst_n low asynchronously forces: state SCAN, pointer 0, counter 0, all pending bits 0, request_valid 0, request_floor 0, request_dir 0.
REQ-028 Reset asserted mid-PRESENT drops the presented call without a dispatch; the lost call is re-registered only by a new button press.

Structure
REQ-029 Shared package elevator_pkg holds NUM_FLOORS, FLOOR_W, dir_t (DIR_DOWN=0, DIR_UP=1) and hall FSM state enum; the building dispatcher imports the same package.
REQ-030 One sub-module, rr_slot_finder: combinational rotating find-first over the 2*NUM_FLOORS pending vector from the pointer, outputs hit and slot index.

Verification
REQ-031 Reset, pulse hall_up_btn[3] one cycle -> up_pending[3]=1 at n+1, request_valid=1 at n+2 with floor 3, dir 1; dispatch_elev_1 pulse -> up_pending[3]=0, request_valid=0 next cycle.
REQ-032 Pending up@2, down@5, up@6, pointer 0, dispatch each immediately -> presentation order (2,up), (5,down), (6,up), then request_valid stays 0.
REQ-033 Pending up@1 only, never dispatch -> presented exactly 15 cycles, one SCAN cycle, re-presented; up_pending[1] stays 1.
REQ-034 hall_up_btn[7] and hall_down_btn[0] held high -> no pending bit, request_valid stays 0.
REQ-035 dispatch_elev_1 and dispatch_elev_2 both high on the 15th PRESENT cycle -> slot cleared, no re-presentation.
REQ-036 rst_n low mid-PRESENT with 3 pending calls -> all outputs 0 immediately (before next clk edge), FSM SCAN after release.
